apb_slave_mem: RTL and testbench
================================

Name: apb_slave_mem

Overview:
APB completer (slave) holding a word-addressed memory. It is the responder for the team's APB master, which is driven through the pclk/presetn interface. Two instances sit behind the master's address decode in the 2-slave APB subsystem. The block supports programmable wait states and flags out-of-range accesses with pslverr.

Parameters:
AW, 8, paddr width in bits.
DW, 8, pwdata/prdata width in bits.
DEPTH, 64, number of DW-bit words; must be <= 2**AW.
WAIT_STATES, 0, ACCESS-phase cycles inserted before pready; legal range 0..15.

Ports:
pclk  input  1  APB clock; all state updates on the rising edge.
presetn  input  1  asynchronous, active-low reset.
psel  input  1  slave select from the master decode.
penable  input  1  APB enable; marks the ACCESS phase.
pwrite  input  1  1 = write, 0 = read.
paddr  input  AW  word address.
pwdata  input  DW  write data.
pready  output  1  transfer complete (registered).
prdata  output  DW  read data (registered); valid while pready=1 on a read.
pslverr  output  1  error response (registered); valid while pready=1.

Behaviour:
- Clocking and reset: one clock, pclk. presetn is asynchronous and active-low.
- Reset values (presetn=0): state=IDLE, wait counter=0, pready=0, prdata=0, pslverr=0, all memory words cleared to 0. Reset takes effect immediately, with no clock required.
- FSM states: IDLE and ACCESS.
- IDLE:
  - psel=1 and penable=0 (setup cycle): on the clock edge, latch paddr, pwrite and pwdata; load cnt=WAIT_STATES; go to ACCESS.
  - psel=1 and penable=1 without a preceding setup: protocol violation; ignore it and stay in IDLE.
- ACCESS:
  - pready is registered and equals 1 in the cycle where cnt==0. With WAIT_STATES=0, pready=1 in the first ACCESS cycle (zero-wait). Otherwise pready=1 exactly WAIT_STATES cycles later. cnt decrements once per ACCESS cycle while cnt>0.
  - Completion happens at the edge where pready=1, psel=1 and penable=1. At that edge:
    - a valid write commits pwdata_latched to mem[addr_latched];
    - the FSM returns to IDLE;
    - pready, pslverr and prdata return to 0 in the next cycle.
  - prdata is loaded from mem[addr_latched] at the edge where pready rises, so prdata is stable for the whole pready cycle. prdata is 0 on writes and on errors.
  - pslverr=1 together with pready when addr_latched >= DEPTH. In that case a write is dropped and read data is 0.
  - psel falls in ACCESS before completion: abort; no write is committed; go to IDLE with pready=0 and pslverr=0.
  - paddr, pwdata or pwrite changing during ACCESS: ignored; the latched setup values are used.
- Back-to-back transfers: a new setup cycle (psel=1, penable=0) in the cycle immediately after completion is accepted from IDLE with no bubble beyond the mandatory APB setup cycle.
- Reset mid-transfer: an in-flight write is not committed. All outputs go to reset values immediately, and the memory clears.
- Address width: only paddr[$clog2(DEPTH)-1:0] indexes the memory. The full AW-bit paddr is compared against DEPTH for the error check.

Decomposition:
- Package apb_pkg:
  - typedef enum apb_slv_state_e {IDLE, ACCESS};
  - default AW/DW localparams, shared with the master and the interface;
  - WAIT_W=4, the counter width.
- Sub-module apb_slave_regfile: DEPTH x DW array with synchronous write enable, combinational read port and asynchronous clear on presetn.
- Top apb_slave_mem: holds the FSM, the setup latches, the wait counter and the response registers.

Test Plan:
- Reset: presetn=0 mid-simulation -> pready=0, pslverr=0, prdata=0 at once; a subsequent read of address 0x05 returns 0x00.
- Zero-wait write then read (WAIT_STATES=0): write 0xA5 to 0x10 -> pready=1 in the first ACCESS cycle, pslverr=0; read 0x10 -> prdata=0xA5 with pready in its first ACCESS cycle.
- Wait states (WAIT_STATES=3): write 0x3C to 0x01 -> pready low for 3 ACCESS cycles, high on the 4th; memory updates only at that edge; read back gives 0x3C.
- Out of range (DEPTH=64): write 0xFF to 0x40 -> pready=1 with pslverr=1, no memory change; read 0x40 -> prdata=0x00, pslverr=1.
- Back-to-back: write 0x11 to 0x02, then immediately read 0x02 with its setup in the cycle after completion -> the read completes with prdata=0x11 and no extra idle cycle.
- Abort and reset mid-access (WAIT_STATES=2): drop psel during ACCESS on a write of 0x77 to 0x03 -> the FSM returns to IDLE and mem[0x03] is unchanged. Separately, assert presetn=0 during ACCESS -> the write is not committed and the outputs are at reset values.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions for the master, the interface and the memory slaves.
//   APB_AW / APB_DW : default address and data widths
//   WAIT_W          : width of the slave wait-state counter (0..15 wait states)
//   apb_slv_state_e : completer FSM states
package apb_pkg;

    localparam int APB_AW = 8;
    localparam int APB_DW = 8;
    localparam int WAIT_W = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_slv_state_e;

    // True when a full-width word address falls outside a DEPTH-word memory.
    function automatic logic addr_out_of_range(input logic [31:0] addr, input int depth);
        return addr >= 32'(depth);
    endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x DW storage for the APB memory slave.
// Ports:
//   pclk, presetn : clock, asynchronous active-low clear of every word
//   we            : synchronous write enable
//   waddr, wdata  : write port
//   raddr, rdata  : combinational read port
module apb_slave_regfile #(
    parameter int DEPTH = 64,
    parameter int DW    = 8,
    parameter int IW    = 6
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [IW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            mem <= '{default: '0};
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer backed by a word-addressed memory, with programmable wait
// states and pslverr on out-of-range addresses.
// Ports:
//   pclk, presetn          : clock, asynchronous active-low reset
//   psel, penable, pwrite  : APB control from the master decode
//   paddr, pwdata          : word address and write data
//   pready, prdata, pslverr: registered response
//
// state  | meaning
// IDLE   | no transfer; a setup cycle (psel & !penable) latches the request
// ACCESS | counting wait states; pready high once the counter reaches 0,
//        | completion when psel & penable & pready
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int AW          = APB_AW,
    parameter int DW          = APB_DW,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          psel,
    input  logic          penable,
    input  logic          pwrite,
    input  logic [AW-1:0] paddr,
    input  logic [DW-1:0] pwdata,
    output logic          pready,
    output logic [DW-1:0] prdata,
    output logic          pslverr
);

    localparam int              IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WAIT_W-1:0] WS_L = WAIT_W'(WAIT_STATES);

    apb_slv_state_e    state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic              pready_d, pslverr_d;
    logic [DW-1:0]     prdata_d;

    logic              rf_we;
    logic [DW-1:0]     rf_rdata;

    logic              setup;
    logic [AW-1:0]     resp_addr;
    logic              resp_wr;
    logic              resp_err;
    logic [DW-1:0]     resp_rdata;

    assign setup = psel && !penable;

    // With zero wait states the response is built at the setup edge, before
    // the request is latched, so it must look at the live bus.
    assign resp_addr = (state_q == IDLE) ? paddr  : addr_q;
    assign resp_wr   = (state_q == IDLE) ? pwrite : wr_q;
    assign resp_err  = addr_out_of_range(32'(resp_addr), DEPTH);
    assign resp_rdata = (resp_wr || resp_err) ? '0 : rf_rdata;

    apb_slave_regfile #(
        .DEPTH(DEPTH),
        .DW   (DW),
        .IW   (IW)
    ) u_regfile (
        .pclk   (pclk),
        .presetn(presetn),
        .we     (rf_we),
        .waddr  (addr_q[IW-1:0]),
        .wdata  (wdata_q),
        .raddr  (resp_addr[IW-1:0]),
        .rdata  (rf_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        pready_d  = pready;
        pslverr_d = pslverr;
        prdata_d  = prdata;
        rf_we     = 1'b0;

        case (state_q)
            IDLE: begin
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
                // psel & penable with no setup falls through and is ignored.
                if (setup) begin
                    addr_d  = paddr;
                    wr_d    = pwrite;
                    wdata_d = pwdata;
                    cnt_d   = WS_L;
                    state_d = ACCESS;
                    if (WS_L == '0) begin
                        pready_d  = 1'b1;
                        pslverr_d = resp_err;
                        prdata_d  = resp_rdata;
                    end
                end
            end

            ACCESS: begin
                if (!psel) begin
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end else if (pready) begin
                    if (penable) begin
                        // pslverr already reflects the latched address.
                        rf_we     = wr_q && !pslverr;
                        state_d   = IDLE;
                        pready_d  = 1'b0;
                        pslverr_d = 1'b0;
                        prdata_d  = '0;
                    end
                end else begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                    // Registered pready: raise it on the edge that takes cnt to 0.
                    if (cnt_q <= WAIT_W'(1)) begin
                        pready_d  = 1'b1;
                        pslverr_d = resp_err;
                        prdata_d  = resp_rdata;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            pready  <= pready_d;
            pslverr <= pslverr_d;
            prdata  <= prdata_d;
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: three instances with 0, 3 and 2 wait states share
// one APB bus (separate psel). A per-instance array holds the expected memory.
module tb_apb_slave_mem;

    localparam int DEPTH = 64;

    logic       pclk = 1'b0;
    logic       presetn;
    logic [2:0] psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [2:0] pready_v;
    logic [2:0] pslverr_v;
    logic [7:0] prdata_v [3];

    int unsigned tests = 0;
    int unsigned fails = 0;
    int          ws_of [3] = '{0, 3, 2};
    logic [7:0]  model [3][DEPTH];

    always #5 pclk = ~pclk;

    apb_slave_mem #(.AW(8), .DW(8), .DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
        .pclk(pclk), .presetn(presetn), .psel(psel[0]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready_v[0]), .prdata(prdata_v[0]), .pslverr(pslverr_v[0]));

    apb_slave_mem #(.AW(8), .DW(8), .DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
        .pclk(pclk), .presetn(presetn), .psel(psel[1]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready_v[1]), .prdata(prdata_v[1]), .pslverr(pslverr_v[1]));

    apb_slave_mem #(.AW(8), .DW(8), .DEPTH(DEPTH), .WAIT_STATES(2)) u_ws2 (
        .pclk(pclk), .presetn(presetn), .psel(psel[2]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready_v[2]), .prdata(prdata_v[2]), .pslverr(pslverr_v[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < DEPTH; j++)
                model[i][j] = 8'h00;
    endtask

    task automatic check_outputs_reset(input string tag);
        for (int i = 0; i < 3; i++) begin
            check({tag, "_pready"}, 32'(pready_v[i]), 0);
            check({tag, "_pslverr"}, 32'(pslverr_v[i]), 0);
            check({tag, "_prdata"}, 32'(prdata_v[i]), 0);
        end
    endtask

    // Full transfer: setup, access, wait for pready. Returns at the negedge
    // where pready is seen; completion happens at the following posedge.
    task automatic xfer(input int idx, input bit wr, input logic [7:0] addr,
                        input logic [7:0] data, input bit scramble);
        int         cyc;
        bit         err;
        logic [7:0] exp_rd;
        @(negedge pclk);
        check("idle_pready", 32'(pready_v[idx]), 0);
        psel      = '0;
        psel[idx] = 1'b1;
        penable   = 1'b0;
        pwrite    = wr;
        paddr     = addr;
        pwdata    = data;
        @(negedge pclk);
        penable = 1'b1;
        cyc     = 0;
        while (!pready_v[idx] && cyc < 20) begin
            if (scramble) begin
                paddr  = 8'($urandom);
                pwdata = 8'($urandom);
                pwrite = 1'($urandom);
            end
            @(negedge pclk);
            cyc++;
        end
        err    = (addr >= DEPTH);
        exp_rd = (wr || err) ? 8'h00 : model[idx][addr[5:0]];
        check("latency", 32'(cyc), 32'(ws_of[idx]));
        check("pslverr", 32'(pslverr_v[idx]), 32'(err));
        check("prdata", 32'(prdata_v[idx]), 32'(exp_rd));
        if (wr && !err) model[idx][addr[5:0]] = data;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge pclk);
            psel    = '0;
            penable = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         idx;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;

        presetn = 1'b0;
        psel    = '0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        clear_model();
        repeat (2) @(negedge pclk);
        check_outputs_reset("por");
        presetn = 1'b1;

        // Zero-wait write then read
        xfer(0, 1'b1, 8'h10, 8'hA5, 1'b0);
        idle(1);
        xfer(0, 1'b0, 8'h10, 8'h00, 1'b0);
        idle(1);

        // Wait states, with the bus scrambled during ACCESS
        xfer(1, 1'b1, 8'h01, 8'h3C, 1'b1);
        idle(1);
        xfer(1, 1'b0, 8'h01, 8'h00, 1'b1);
        idle(1);

        // Out of range
        xfer(0, 1'b1, 8'h40, 8'hFF, 1'b0);
        idle(1);
        xfer(0, 1'b0, 8'h40, 8'h00, 1'b0);
        xfer(0, 1'b0, 8'h00, 8'h00, 1'b0);
        idle(1);

        // Back-to-back: read setup in the cycle right after write completion
        xfer(0, 1'b1, 8'h02, 8'h11, 1'b0);
        xfer(0, 1'b0, 8'h02, 8'h00, 1'b0);
        xfer(1, 1'b1, 8'h02, 8'h22, 1'b0);
        xfer(1, 1'b0, 8'h02, 8'h00, 1'b0);
        idle(1);

        // Enable without setup is ignored
        @(negedge pclk);
        psel[1] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h20; pwdata = 8'hEE;
        repeat (3) begin
            @(negedge pclk);
            check("no_setup_pready", 32'(pready_v[1]), 0);
        end
        idle(1);
        xfer(1, 1'b0, 8'h20, 8'h00, 1'b0);
        idle(1);

        // Abort: psel drops during ACCESS of a write
        xfer(2, 1'b1, 8'h03, 8'h55, 1'b0);
        idle(1);
        @(negedge pclk);
        psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 8'h03; pwdata = 8'h77;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        psel = '0; penable = 1'b0;
        @(negedge pclk);
        check("abort_pready", 32'(pready_v[2]), 0);
        check("abort_pslverr", 32'(pslverr_v[2]), 0);
        xfer(2, 1'b0, 8'h03, 8'h00, 1'b0);
        idle(1);

        // Random traffic across the three instances
        repeat (60) begin
            idx  = int'($urandom_range(0, 2));
            wr   = 1'($urandom);
            addr = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(64, 255))
                                               : 8'($urandom_range(0, 15));
            data = 8'($urandom);
            xfer(idx, wr, addr, data, 1'b1);
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(1);

        // Reset while a read response is being presented
        xfer(0, 1'b1, 8'h05, 8'h99, 1'b0);
        idle(1);
        xfer(0, 1'b0, 8'h05, 8'h00, 1'b0);
        #2;
        presetn = 1'b0;
        #1;
        check_outputs_reset("async_rst");
        clear_model();
        @(negedge pclk);
        psel = '0; penable = 1'b0;
        presetn = 1'b1;
        xfer(0, 1'b0, 8'h05, 8'h00, 1'b0);
        idle(1);

        // Reset in the middle of a waited write
        xfer(2, 1'b1, 8'h03, 8'h44, 1'b0);
        idle(1);
        @(negedge pclk);
        psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 8'h03; pwdata = 8'h77;
        @(negedge pclk);
        penable = 1'b1;
        #2;
        presetn = 1'b0;
        #1;
        check_outputs_reset("rst_access");
        clear_model();
        @(negedge pclk);
        psel = '0; penable = 1'b0;
        presetn = 1'b1;
        xfer(2, 1'b0, 8'h03, 8'h00, 1'b0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
